mig_cmd_prbs_chk_axi: RTL

Receive-side checker for the PRBS command address stream produced by the traffic generator's 32-bit address LFSR. It is seeded with the same seed as the generator. It regenerates the expected address per accepted command beat, compares it against the observed AXI command address, and reports mismatches through a sticky flag, a per-beat pulse and counters. It sits on the AXI AR/AW observation path of the DRAM traffic-test block, downstream of the command arbiter.

---
 rtl/mig_cmd_prbs_chk_axi.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mig_cmd_prbs_chk_axi.sv
// mig_cmd_prbs_chk_axi
// Receive-side checker for the PRBS command address stream. Regenerates the
// traffic generator's 32-bit address LFSR from a shared seed, compares each
// accepted AXI command beat against the expected address and reports
// mismatches through a sticky flag, a per-beat pulse and saturating counters.
//
// Optional build macro CMD_PRBS_CHK_ERR_LOG_EN: when defined, the observed and
// expected addresses of the first mismatch after a seed load are captured;
// when undefined, first_err_addr_o/first_err_exp_o are tied to zero.
module mig_cmd_prbs_chk_axi #(
  parameter int                       TCQ                 = 100,
  parameter int unsigned              ADDR_WIDTH          = 32,
  parameter int unsigned              SEED_WIDTH          = 32,
  parameter int unsigned              ADDR_LSB_ZERO       = 3,
  parameter logic [ADDR_WIDTH-1:0]    PRBS_SADDR_MASK_POS = ADDR_WIDTH'(32'h00002000),
  parameter logic [ADDR_WIDTH-1:0]    PRBS_EADDR_MASK_POS = ADDR_WIDTH'(32'hFFFFD000),
  parameter logic [ADDR_WIDTH-1:0]    PRBS_SADDR          = ADDR_WIDTH'(32'h00002000),
  parameter logic [ADDR_WIDTH-1:0]    PRBS_EADDR          = ADDR_WIDTH'(32'h00002000),
  parameter int unsigned              CNT_WIDTH           = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  prbs_seed_init,
  input  logic [SEED_WIDTH-1:0] prbs_seed_i,
  input  logic                  cmd_valid_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  output logic                  locked_o,
  output logic                  err_o,
  output logic                  err_pulse_o,
  output logic [CNT_WIDTH-1:0]  beat_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic [ADDR_WIDTH-1:0] first_err_exp_o
);

  // Elaboration guards on parameter ranges the datapath relies on.
  if (ADDR_LSB_ZERO < 1 || ADDR_LSB_ZERO > 8) begin : g_bad_lsb
    $error("ADDR_LSB_ZERO must be in 1..8");
  end
  if (SEED_WIDTH < 8 || ADDR_WIDTH > SEED_WIDTH) begin : g_bad_width
    $error("SEED_WIDTH must be >= 8 and >= ADDR_WIDTH");
  end
  if (TCQ < 0) begin : g_bad_tcq
    $error("TCQ must be non-negative");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [SEED_WIDTH-1:0]   lfsr_q;
  logic [SEED_WIDTH-1:0]   lfsr_adv_c;
  logic [ADDR_WIDTH-1:0]   exp_addr_c;
  logic                    mism_c;
  logic                    chk_c;
  logic                    first_c;

  // Expected address derived from the current LFSR state.
  always_comb begin
    exp_addr_c = '0;
    for (int unsigned i = ADDR_LSB_ZERO; i < ADDR_WIDTH; i++) begin
      if (PRBS_SADDR_MASK_POS[i])
        exp_addr_c[i] = PRBS_SADDR[i] | lfsr_q[i];
      else if (PRBS_EADDR_MASK_POS[i])
        exp_addr_c[i] = PRBS_EADDR[i] & lfsr_q[i];
      else
        exp_addr_c[i] = lfsr_q[i];
    end
  end

  // LFSR advance: rotate left, then fold the old MSB into taps 7, 6 and 2.
  always_comb begin
    lfsr_adv_c    = {lfsr_q[SEED_WIDTH-2:0], lfsr_q[SEED_WIDTH-1]};
    lfsr_adv_c[7] = lfsr_adv_c[7] ^ lfsr_q[SEED_WIDTH-1];
    lfsr_adv_c[6] = lfsr_adv_c[6] ^ lfsr_q[SEED_WIDTH-1];
    lfsr_adv_c[2] = lfsr_adv_c[2] ^ lfsr_q[SEED_WIDTH-1];
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a seed load always wins over a coincident beat.
  always_comb begin
    state_d = state_q;
    chk_c   = 1'b0;
    first_c = 1'b0;
    mism_c  = (cmd_addr_i != exp_addr_c);
    case (state_q)
      ST_IDLE: begin
        if (prbs_seed_init) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (prbs_seed_init) begin
          state_d = ST_RUN;
        end else if (cmd_valid_i) begin
          chk_c = 1'b1;
          if (mism_c) begin
            state_d = ST_FAIL;
            first_c = 1'b1;
          end
        end
      end
      ST_FAIL: begin
        if (prbs_seed_init) state_d = ST_RUN;
        else if (cmd_valid_i) chk_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Checker datapath: LFSR, status flags and saturating counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q      <= '0;
      locked_o    <= 1'b0;
      err_o       <= 1'b0;
      err_pulse_o <= 1'b0;
      beat_cnt_o  <= '0;
      err_cnt_o   <= '0;
    end else if (prbs_seed_init) begin
      lfsr_q      <= prbs_seed_i;
      locked_o    <= 1'b1;
      err_o       <= 1'b0;
      err_pulse_o <= 1'b0;
      beat_cnt_o  <= '0;
      err_cnt_o   <= '0;
    end else begin
      err_pulse_o <= chk_c & mism_c;
      if (chk_c) begin
        lfsr_q <= lfsr_adv_c;
        if (beat_cnt_o != '1) beat_cnt_o <= beat_cnt_o + CNT_WIDTH'(1);
        if (mism_c) begin
          err_o <= 1'b1;
          if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
        end
      end
    end
  end

`ifdef CMD_PRBS_CHK_ERR_LOG_EN
  // First-mismatch capture, held until the next seed load or reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_err_addr_o <= '0;
      first_err_exp_o  <= '0;
    end else if (prbs_seed_init) begin
      first_err_addr_o <= '0;
      first_err_exp_o  <= '0;
    end else if (first_c) begin
      first_err_addr_o <= cmd_addr_i;
      first_err_exp_o  <= exp_addr_c;
    end
  end
`else
  // Capture logic not built.
  logic unused_first_c;
  assign unused_first_c   = first_c;
  assign first_err_addr_o = '0;
  assign first_err_exp_o  = '0;
`endif

endmodule
